// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single unified memory port: one transaction
// in flight at a time, fixed memory latency, and bounded starvation of the DMA side.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state_reg;
    logic       owner_reg;      // 0 = core, 1 = DMA
    logic [3:0] lat_cnt_reg;
    logic [3:0] wait_cnt_reg;

    logic idle_active;
    logic d_win;
    logic done;

    // Grants are combinational so a request in IDLE reaches memory the same cycle;
    // gating with rst_n keeps every output quiet while reset is held.
    assign idle_active = rst_n && (state_reg == IDLE);
    assign d_win       = d_req && (!c_req || (wait_cnt_reg == WAIT_MAX));
    assign c_gnt       = idle_active && c_req && !d_win;
    assign d_gnt       = idle_active && d_win;

    assign mem_en    = c_gnt || d_gnt;
    assign mem_we    = c_gnt ? c_we    : (d_gnt ? d_we    : 1'b0);
    assign mem_addr  = c_gnt ? c_addr  : (d_gnt ? d_addr  : '0);
    assign mem_wdata = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);

    assign done     = rst_n && (state_reg == BUSY) && (lat_cnt_reg == 4'd0);
    assign c_rvalid = done && !owner_reg;
    assign d_rvalid = done && owner_reg;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            lat_cnt_reg  <= 4'd0;
            wait_cnt_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_en) begin
                        owner_reg   <= d_gnt;
                        lat_cnt_reg <= LAT_INIT;
                        state_reg   <= BUSY;
                        // Count consecutive core wins that left the DMA waiting.
                        if (c_gnt && d_req) begin
                            if (wait_cnt_reg != WAIT_MAX)
                                wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        end else begin
                            wait_cnt_reg <= 4'd0;
                        end
                    end
                end
                BUSY: begin
                    if (lat_cnt_reg == 4'd0)
                        state_reg <= IDLE;
                    else
                        lat_cnt_reg <= lat_cnt_reg - 4'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A runs with MEM_LAT=1, instance B with MEM_LAT=3 (both MAX_WAIT=4).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Instance A (MEM_LAT=1)
    logic        a_rst_n;
    logic        a_c_req, a_c_we, a_d_req, a_d_we;
    logic [31:0] a_c_addr, a_c_wdata, a_d_addr, a_d_wdata, a_mem_rdata;
    logic        a_c_gnt, a_c_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_c_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;

    // Instance B (MEM_LAT=3)
    logic        b_rst_n;
    logic        b_c_req, b_c_we, b_d_req, b_d_we;
    logic [31:0] b_c_addr, b_c_wdata, b_d_addr, b_d_wdata, b_mem_rdata;
    logic        b_c_gnt, b_c_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Inputs are driven just after the falling edge and outputs sampled 2 time units later.
    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_c_req = 1'b0; a_c_we = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_c_addr = '0; a_c_wdata = '0; a_d_addr = '0; a_d_wdata = '0; a_mem_rdata = '0;
        b_c_req = 1'b0; b_c_we = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_c_addr = '0; b_c_wdata = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;
        @(negedge clk);
        a_c_req = 1'b1; a_c_addr = 32'h44; a_mem_rdata = 32'h1111_2222;
        #2;
        total++;
        if ({a_c_gnt, a_d_gnt, a_mem_en, a_mem_we, a_c_rvalid, a_d_rvalid} !== 6'b0 ||
            a_mem_addr !== 32'h0 || a_c_rdata !== 32'h0)
            $display("FAIL reset_hold: gnt/en/rv=%b addr=%h, required all 0",
                     {a_c_gnt, a_d_gnt, a_mem_en, a_mem_we, a_c_rvalid, a_d_rvalid}, a_mem_addr);
        else passed++;
        @(negedge clk);
        a_c_req = 1'b0; a_rst_n = 1'b1; b_rst_n = 1'b1;
        #2;
        total++;
        if ({a_c_gnt, a_d_gnt, a_mem_en, a_c_rvalid, a_d_rvalid, b_mem_en, b_c_rvalid} !== 7'b0 ||
            a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0)
            $display("FAIL reset_idle: outputs=%b addr=%h, required all 0",
                     {a_c_gnt, a_d_gnt, a_mem_en, a_c_rvalid, a_d_rvalid, b_mem_en, b_c_rvalid}, a_mem_addr);
        else passed++;
        $display("tx reset done");
    endtask

    task automatic test_c_read();
        @(negedge clk);
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h10; a_c_wdata = 32'h77; a_mem_rdata = 32'hDEADBEEF;
        #2;
        total++;
        if ({a_c_gnt, a_d_gnt, a_mem_en, a_mem_we} !== 4'b1010 || a_mem_addr !== 32'h10)
            $display("FAIL c_read_grant: gnt_c/gnt_d/en/we=%b addr=%h, required 1010 addr=00000010",
                     {a_c_gnt, a_d_gnt, a_mem_en, a_mem_we}, a_mem_addr);
        else passed++;
        @(negedge clk);
        a_c_req = 1'b0;
        #2;
        total++;
        if ({a_c_rvalid, a_d_rvalid, a_c_gnt, a_mem_en} !== 4'b1000 ||
            a_c_rdata !== 32'hDEADBEEF || a_d_rdata !== 32'h0 || a_mem_addr !== 32'h0)
            $display("FAIL c_read_rvalid: rv_c/rv_d/gnt/en=%b c_rdata=%h d_rdata=%h, required 1000 deadbeef 0",
                     {a_c_rvalid, a_d_rvalid, a_c_gnt, a_mem_en}, a_c_rdata, a_d_rdata);
        else passed++;
        @(negedge clk);
        #2;
        total++;
        if ({a_c_rvalid, a_d_rvalid, a_c_gnt, a_d_gnt, a_mem_en} !== 5'b0 || a_c_rdata !== 32'h0)
            $display("FAIL c_read_after: flags=%b c_rdata=%h, required 0",
                     {a_c_rvalid, a_d_rvalid, a_c_gnt, a_d_gnt, a_mem_en}, a_c_rdata);
        else passed++;
        $display("tx C read 0x10 -> deadbeef");
    endtask

    task automatic test_d_write();
        @(negedge clk);
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h20; b_d_wdata = 32'h1234; b_mem_rdata = 32'h0BAD_0BAD;
        #2;
        total++;
        if ({b_c_gnt, b_d_gnt, b_mem_en, b_mem_we} !== 4'b0111 ||
            b_mem_addr !== 32'h20 || b_mem_wdata !== 32'h1234)
            $display("FAIL d_write_grant: flags=%b addr=%h wdata=%h, required 0111 20 1234",
                     {b_c_gnt, b_d_gnt, b_mem_en, b_mem_we}, b_mem_addr, b_mem_wdata);
        else passed++;
        // Request stays high: it must not be re-granted until after rvalid.
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            #2;
            total++;
            if ({b_d_gnt, b_mem_en, b_d_rvalid, b_c_rvalid} !== 4'b0 || b_mem_wdata !== 32'h0)
                $display("FAIL d_write_busy%0d: gnt/en/rv_d/rv_c=%b wdata=%h, required 0000 0",
                         k, {b_d_gnt, b_mem_en, b_d_rvalid, b_c_rvalid}, b_mem_wdata);
            else passed++;
        end
        @(negedge clk);
        #2;
        total++;
        if ({b_d_rvalid, b_d_gnt, b_c_rvalid, b_mem_en} !== 4'b1000 || b_c_rdata !== 32'h0)
            $display("FAIL d_write_ack: rv_d/gnt/rv_c/en=%b c_rdata=%h, required 1000 0",
                     {b_d_rvalid, b_d_gnt, b_c_rvalid, b_mem_en}, b_c_rdata);
        else passed++;
        @(negedge clk);
        #2;
        total++;
        if ({b_d_gnt, b_mem_en, b_d_rvalid} !== 3'b110)
            $display("FAIL d_write_regrant: gnt/en/rv=%b, required 110",
                     {b_d_gnt, b_mem_en, b_d_rvalid});
        else passed++;
        b_d_req = 1'b0; b_d_we = 1'b0;
        repeat (4) @(negedge clk);
        $display("tx D write 0x20 <- 0x1234");
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 32'h30;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h40; a_mem_rdata = 32'h600D_F00D;
        #2;
        total++;
        if ({a_c_gnt, a_d_gnt, a_mem_en} !== 3'b101 || a_mem_addr !== 32'h30)
            $display("FAIL simul_c_first: gnt_c/gnt_d/en=%b addr=%h, required 101 30",
                     {a_c_gnt, a_d_gnt, a_mem_en}, a_mem_addr);
        else passed++;
        @(negedge clk);
        a_c_req = 1'b0;
        #2;
        total++;
        if ({a_c_rvalid, a_d_gnt, a_c_gnt} !== 3'b100)
            $display("FAIL simul_no_handoff: rv_c/gnt_d/gnt_c=%b, required 100",
                     {a_c_rvalid, a_d_gnt, a_c_gnt});
        else passed++;
        @(negedge clk);
        #2;
        total++;
        if ({a_d_gnt, a_c_gnt, a_mem_en} !== 3'b101 || a_mem_addr !== 32'h40)
            $display("FAIL simul_d_next: gnt_d/gnt_c/en=%b addr=%h, required 101 40",
                     {a_d_gnt, a_c_gnt, a_mem_en}, a_mem_addr);
        else passed++;
        @(negedge clk);
        a_d_req = 1'b0;
        #2;
        total++;
        if ({a_d_rvalid, a_c_rvalid} !== 2'b10 || a_d_rdata !== 32'h600D_F00D || a_c_rdata !== 32'h0)
            $display("FAIL simul_d_rdata: rv_d/rv_c=%b d_rdata=%h c_rdata=%h, required 10 600df00d 0",
                     {a_d_rvalid, a_c_rvalid}, a_d_rdata, a_c_rdata);
        else passed++;
        repeat (2) @(negedge clk);
        $display("tx simultaneous C then D");
    endtask

    task automatic test_starvation();
        logic exp_d;
        @(negedge clk);
        a_c_req = 1'b1; a_c_addr = 32'h100; a_d_req = 1'b1; a_d_addr = 32'h200; a_mem_rdata = 32'h55AA;
        for (int i = 0; i < 10; i++) begin
            exp_d = ((i % 5) == 4);
            if (i != 0) @(negedge clk);
            #2;
            total++;
            if ({a_c_gnt, a_d_gnt, a_mem_en} !== {~exp_d, exp_d, 1'b1} ||
                a_mem_addr !== (exp_d ? 32'h200 : 32'h100))
                $display("FAIL starve_grant%0d: gnt_c/gnt_d/en=%b addr=%h, required %b",
                         i, {a_c_gnt, a_d_gnt, a_mem_en}, a_mem_addr, {~exp_d, exp_d, 1'b1});
            else passed++;
            $display("tx starvation grant %0d -> %s", i, a_d_gnt ? "D" : "C");
            @(negedge clk);
            #2;
            total++;
            if ({a_c_rvalid, a_d_rvalid, a_c_gnt, a_d_gnt} !== {~exp_d, exp_d, 2'b00})
                $display("FAIL starve_rvalid%0d: rv_c/rv_d/gnt_c/gnt_d=%b, required %b",
                         i, {a_c_rvalid, a_d_rvalid, a_c_gnt, a_d_gnt}, {~exp_d, exp_d, 2'b00});
            else passed++;
        end
        @(negedge clk);
        a_c_req = 1'b0; a_d_req = 1'b0;
        #2;
        total++;
        if ({a_c_gnt, a_d_gnt, a_mem_en} !== 3'b0 || a_mem_addr !== 32'h0)
            $display("FAIL starve_idle: flags=%b addr=%h, required 0 0",
                     {a_c_gnt, a_d_gnt, a_mem_en}, a_mem_addr);
        else passed++;
    endtask

    task automatic test_busy_hold();
        @(negedge clk);
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'h50; b_mem_rdata = 32'hCAFEF00D;
        #2;
        total++;
        if ({b_c_gnt, b_mem_en} !== 2'b11) $display("FAIL busy_grant: gnt/en=%b, required 11", {b_c_gnt, b_mem_en});
        else passed++;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            #2;
            total++;
            if ({b_c_gnt, b_mem_en, b_c_rvalid} !== 3'b0)
                $display("FAIL busy_hold%0d: gnt/en/rv=%b, required 000", k, {b_c_gnt, b_mem_en, b_c_rvalid});
            else passed++;
        end
        @(negedge clk);
        #2;
        total++;
        if ({b_c_rvalid, b_c_gnt, b_d_rvalid} !== 3'b100 || b_c_rdata !== 32'hCAFEF00D || b_d_rdata !== 32'h0)
            $display("FAIL busy_rvalid: rv_c/gnt/rv_d=%b c_rdata=%h d_rdata=%h, required 100 cafef00d 0",
                     {b_c_rvalid, b_c_gnt, b_d_rvalid}, b_c_rdata, b_d_rdata);
        else passed++;
        @(negedge clk);
        #2;
        total++;
        if ({b_c_gnt, b_mem_en} !== 2'b11) $display("FAIL busy_regrant: gnt/en=%b, required 11", {b_c_gnt, b_mem_en});
        else passed++;
        b_c_req = 1'b0;
        repeat (4) @(negedge clk);
        $display("tx C held request during BUSY");
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        b_c_req = 1'b1; b_c_addr = 32'h60; b_mem_rdata = 32'h1357_9BDF;
        #2;
        total++;
        if (b_c_gnt !== 1'b1) $display("FAIL rstbusy_grant: c_gnt=%b, required 1", b_c_gnt);
        else passed++;
        @(negedge clk);
        b_c_req = 1'b0; b_rst_n = 1'b0;
        #2;
        total++;
        if ({b_c_gnt, b_d_gnt, b_mem_en, b_c_rvalid, b_d_rvalid} !== 5'b0 || b_c_rdata !== 32'h0)
            $display("FAIL rstbusy_outputs: flags=%b c_rdata=%h, required 0",
                     {b_c_gnt, b_d_gnt, b_mem_en, b_c_rvalid, b_d_rvalid}, b_c_rdata);
        else passed++;
        @(negedge clk);
        #2;
        total++;
        if ({b_c_rvalid, b_d_rvalid} !== 2'b00)
            $display("FAIL rstbusy_no_rvalid: rv=%b, required 00", {b_c_rvalid, b_d_rvalid});
        else passed++;
        @(negedge clk);
        b_rst_n = 1'b1; b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h70;
        #2;
        total++;
        if ({b_d_gnt, b_c_gnt, b_mem_en, b_c_rvalid} !== 4'b1010 || b_mem_addr !== 32'h70)
            $display("FAIL rstbusy_d_grant: gnt_d/gnt_c/en/rv_c=%b addr=%h, required 1010 70",
                     {b_d_gnt, b_c_gnt, b_mem_en, b_c_rvalid}, b_mem_addr);
        else passed++;
        b_d_req = 1'b0;
        repeat (4) @(negedge clk);
        $display("tx reset during BUSY");
    endtask

    initial begin
        test_reset();
        test_c_read();
        test_d_write();
        test_simultaneous();
        test_starvation();
        test_busy_hold();
        test_reset_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
